// File: rtl/pcie_cfg_pkg.sv
// Shared types and Device Control/Status field layout for the config-management responder.
package pcie_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the combined Device Control / Device Status dword
    localparam int MPS_LSB  = 5;
    localparam int MRRS_LSB = 12;
    localparam int STAT_LSB = 16;

    localparam logic [3:0]  STAT_W1C_MASK = 4'hF;
    localparam logic [31:0] DEVCTL_RST    = 32'h0000_2000;

endpackage

// File: rtl/pcie_cfg_mgmt_responder.sv
// Config-management responder: serves cfg_mgmt reads/writes from a small dword register file
// with fixed latency, and exports Device Control decodes and latched error status.
//
// state | meaning
// IDLE  | waiting for a read or write request; request fields latched on accept
// WAIT  | counting down the access latency
// DONE  | one-cycle completion; commit/capture happened on the edge into this state
module pcie_cfg_mgmt_responder
    import pcie_cfg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 19,
    parameter int          NUM_REGS   = 64,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] ID_VALUE   = 32'h7038_10EE,
    parameter logic [9:0]  DEVCTL_IDX = 10'h01E
) (
    input  logic                  clk_250mhz,
    input  logic                  rst_250mhz_n,
    input  logic [ADDR_WIDTH-1:0] cfg_mgmt_addr,
    input  logic                  cfg_mgmt_write,
    input  logic [31:0]           cfg_mgmt_write_data,
    input  logic [3:0]            cfg_mgmt_byte_enable,
    input  logic                  cfg_mgmt_read,
    output logic [31:0]           cfg_mgmt_read_data,
    output logic                  cfg_mgmt_read_write_done,
    input  logic                  cfg_err_cor_in,
    input  logic                  cfg_err_uncor_in,
    output logic [2:0]            cfg_max_payload,
    output logic [2:0]            cfg_max_read_req
);

    localparam int         IDX_W       = $clog2(NUM_REGS);
    localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);
    localparam logic [IDX_W-1:0] DEVCTL_SLOT = DEVCTL_IDX[IDX_W-1:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [9:0]  idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        write_q;

    logic        req;
    logic        in_idle;
    logic        commit;
    logic [9:0]  idx_cur;
    logic [31:0] wdata_cur;
    logic [3:0]  be_cur;
    logic        write_cur;
    logic        in_range;
    logic        is_id;
    logic        is_devctl;
    logic [IDX_W-1:0] slot;
    logic [31:0] rd_value;
    logic [3:0]  status_q, status_d, w1c_clear, err_set;

    logic [31:0] regs [NUM_REGS];

    // Only the low ten address bits are decoded; the rest are accepted and ignored.
    logic unused_addr;
    assign unused_addr = ^cfg_mgmt_addr;

    assign req     = cfg_mgmt_read | cfg_mgmt_write;
    assign in_idle = (state_q == IDLE);

    // With LATENCY=1 the commit happens on the accept edge, so use the live request fields there.
    assign idx_cur   = in_idle ? cfg_mgmt_addr[9:0]   : idx_q;
    assign wdata_cur = in_idle ? cfg_mgmt_write_data  : wdata_q;
    assign be_cur    = in_idle ? cfg_mgmt_byte_enable : be_q;
    assign write_cur = in_idle ? cfg_mgmt_write       : write_q;

    assign in_range  = ({1'b0, idx_cur} < 11'(NUM_REGS));
    assign is_id     = (idx_cur == 10'd0);
    assign is_devctl = (idx_cur == DEVCTL_IDX);
    assign slot      = idx_cur[IDX_W-1:0];

    always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
        if (!rst_250mhz_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
        if (!rst_250mhz_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else if (in_idle && req) begin
            cnt_q   <= CNT_LOAD;
            idx_q   <= cfg_mgmt_addr[9:0];
            wdata_q <= cfg_mgmt_write_data;
            be_q    <= cfg_mgmt_byte_enable;
            write_q <= cfg_mgmt_write;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_comb begin
        rd_value = '0;
        if (is_id) begin
            rd_value = ID_VALUE;
        end else if (!in_range) begin
            rd_value = '0;
        end else if (is_devctl) begin
            rd_value = {12'h000, regs[DEVCTL_SLOT][19:0]};
        end else begin
            rd_value = regs[slot];
        end
    end

    // Error set is ORed in after the W1C clear so a coincident pulse wins.
    assign status_q  = regs[DEVCTL_SLOT][STAT_LSB +: 4];
    assign w1c_clear = (commit && write_cur && is_devctl && be_cur[2])
                       ? (wdata_cur[STAT_LSB +: 4] & STAT_W1C_MASK) : 4'h0;
    assign err_set   = {2'b00, cfg_err_uncor_in, cfg_err_cor_in};
    assign status_d  = (status_q & ~w1c_clear) | err_set;

    always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
        if (!rst_250mhz_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (10'(i) == DEVCTL_IDX) ? DEVCTL_RST : 32'h0;
            end
        end else begin
            if (commit && write_cur && in_range && !is_id && !is_devctl) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_cur[b]) regs[slot][8*b +: 8] <= wdata_cur[8*b +: 8];
                end
            end
            if (commit && write_cur && is_devctl) begin
                for (int b = 0; b < 2; b++) begin
                    if (be_cur[b]) regs[DEVCTL_SLOT][8*b +: 8] <= wdata_cur[8*b +: 8];
                end
            end
            regs[DEVCTL_SLOT][STAT_LSB +: 4] <= status_d;
            regs[DEVCTL_SLOT][31:20]         <= 12'h000;
        end
    end

    always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
        if (!rst_250mhz_n) begin
            cfg_mgmt_read_data <= '0;
        end else if (commit && !write_cur) begin
            cfg_mgmt_read_data <= rd_value;
        end
    end

    assign cfg_mgmt_read_write_done = (state_q == DONE);
    assign cfg_max_payload          = regs[DEVCTL_SLOT][MPS_LSB +: 3];
    assign cfg_max_read_req         = regs[DEVCTL_SLOT][MRRS_LSB +: 3];

endmodule
